multiword_adder_seq: RTL and testbench



---
 rtl/adder_pkg.sv | 16 +
 rtl/fulladder_chain.sv | 23 ++
 rtl/multiword_adder_seq.sv | 115 +++++++++++
 tb/tb_multiword_adder_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types for the sequential multi-word adder: controller states and
// the word-index width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-word configuration still needs a one-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/fulladder_chain.sv
// WIDTH-bit ripple-carry adder slice built from full-adder cells.
module fulladder_chain #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-precision add/subtract that walks one shared WIDTH-bit slice across
// WORDS words, least significant first, with valid/ready on both ends.
module multiword_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic                     sub,
    input  logic [WIDTH*WORDS-1:0]   a,
    input  logic [WIDTH*WORDS-1:0]   b,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [WIDTH*WORDS-1:0]   sum,
    output logic                     carry_out,
    output logic                     overflow
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t state, state_next;

    logic [WORDS-1:0][WIDTH-1:0] a_q;
    logic [WORDS-1:0][WIDTH-1:0] b_q;
    logic [WORDS-1:0][WIDTH-1:0] sum_q;
    logic [IDX_W-1:0]            idx;
    logic                        carry_q;
    logic                        carry_out_q;
    logic                        overflow_q;

    logic [WIDTH-1:0]            slice_sum;
    logic                        slice_cout;
    logic                        last_word;

    assign last_word = (idx == LAST_IDX);

    fulladder_chain #(.WIDTH(WIDTH)) u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid)  state_next = RUN;
            RUN:     if (last_word)    state_next = DONE;
            DONE:    if (result_ready) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
    end

    // Subtraction is a + ~b + 1: b is inverted at load and the +1 enters as
    // the initial carry, so the slice never needs to know the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx         <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        sum_q   <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx] <= slice_sum;
                    carry_q    <= slice_cout;
                    if (last_word) begin
                        carry_out_q <= slice_cout;
                        overflow_q  <= (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
                                       (slice_sum[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq (WIDTH=8, WORDS=4).
module tb_multiword_adder_seq;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int TW    = WIDTH * WORDS;
    localparam int LAT   = WORDS;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic          sub;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          result_valid;
    logic          result_ready;
    logic [TW-1:0] sum;
    logic          carry_out;
    logic          overflow;

    multiword_adder_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .sub          (sub),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .carry_out    (carry_out),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          sub;
        logic [TW-1:0] sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Independent reference: full-width add with the operation folded in.
    function automatic exp_t model(input logic [TW-1:0] ia, input logic [TW-1:0] ib, input logic isub);
        exp_t        e;
        logic [TW-1:0] bb;
        logic [TW:0]   full;
        bb     = isub ? ~ib : ib;
        full   = {1'b0, ia} + {1'b0, bb} + {{TW{1'b0}}, isub};
        e.sum  = full[TW-1:0];
        e.cout = full[TW];
        e.ovf  = (ia[TW-1] == bb[TW-1]) && (full[TW-1] != ia[TW-1]);
        return e;
    endfunction

    // Issue one operation and score it; inputs are scrambled while it runs.
    task automatic do_op(input logic [TW-1:0] ia, input logic [TW-1:0] ib, input logic isub,
                         input exp_t e, input string tag);
        int   cyc;
        exp_t got;
        cyc = 0;
        start_valid = 1'b1;
        a = ia; b = ib; sub = isub;
        while (!start_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!start_ready) begin
            check({tag, "_start_ready_timeout"}, 64'(start_ready), 64'd1);
            start_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        sb.push_back(e);
        cyc = 0;
        while (!result_valid && cyc < 20) begin
            a = $urandom; b = $urandom; sub = 1'($urandom);
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        if (result_valid) begin
            got = sb.pop_front();
            check({tag, "_sum"},  64'(sum),       64'(got.sum));
            check({tag, "_cout"}, 64'(carry_out), 64'(got.cout));
            check({tag, "_ovf"},  64'(overflow),  64'(got.ovf));
        end
        if (result_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_t        e;
        exp_t        held;
        logic [TW-1:0] ra, rb;
        logic        rs;
        int          cyc;

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start_valid = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        result_ready = 1'b1;

        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[7] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready",  64'(start_ready),  64'd1);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_sum",          64'(sum),          64'd0);
        check("rst_cout",         64'(carry_out),    64'd0);
        check("rst_ovf",          64'(overflow),     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, e, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            do_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
        end

        // Backpressure: result held while inputs churn and start is requested.
        result_ready = 1'b0;
        held = model(32'h12345678, 32'h11111111, 1'b0);
        do_op(32'h12345678, 32'h11111111, 1'b0, held, "bp");
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom);
            start_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp_start_ready_%0d", i),  64'(start_ready),  64'd0);
            check($sformatf("bp_result_valid_%0d", i), 64'(result_valid), 64'd1);
            check($sformatf("bp_sum_%0d", i),          64'(sum),          64'(held.sum));
            check($sformatf("bp_cout_%0d", i),         64'(carry_out),    64'(held.cout));
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(result_valid), 64'd0);
        check("bp_release_ready", 64'(start_ready),  64'd1);
        check("bp_release_sum",   64'(sum),          64'(held.sum));
        start_valid = 1'b0;
        do_op(32'h00000003, 32'h00000004, 1'b0, model(32'h3, 32'h4, 1'b0), "bp_next");

        // Abort in the middle of RUN.
        start_valid = 1'b1;
        a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_sum",          64'(sum),          64'd0);
        check("abort_result_valid", 64'(result_valid), 64'd0);
        check("abort_start_ready",  64'(start_ready),  64'd1);
        check("abort_cout",         64'(carry_out),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        e.sum = 32'h00000030; e.cout = 1'b0; e.ovf = 1'b0;
        do_op(32'h00000010, 32'h00000020, 1'b0, e, "post_abort");

        cyc = sb.size();
        check("scoreboard_empty", 64'(cyc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
